// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch queue: issues sequential PC requests and buffers returned instructions for IF.
// Latency: request accepted at N, response at N+k, instValidF at N+k+1 (same cycle with FETCH_BYPASS_EN).
// Backpressure: stallF holds the head; issue stops once buffered + outstanding reaches DEPTH, nothing is lost.
//
// Optional feature macro: FETCH_BYPASS_EN -- when the FIFO is empty a kept response is
// presented on instF/pcF in the cycle it arrives and is only written if not popped.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   jump, jumpAddr      single-cycle redirect and its 4-byte aligned target
//   stallF              IF not accepting; blocks the pop
//   reqValid/reqAddr    fetch request (accept-on-cycle with reqReady)
//   reqReady            memory accepts the request this cycle
//   respValid/respData  in-order instruction return
//   instValidF/instF/pcF head of the instruction stream to IF
module ifu_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jumpAddr,
    input  logic              stallF,
    output logic              reqValid,
    output logic [ADDR_W-1:0] reqAddr,
    input  logic              reqReady,
    input  logic              respValid,
    input  logic [INST_W-1:0] respData,
    output logic              instValidF,
    output logic [INST_W-1:0] instF,
    output logic [ADDR_W-1:0] pcF
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    // Architectural state
    logic [ADDR_W-1:0] fetchPc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outCnt;
    logic [CW-1:0]     dropCnt;
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [PW-1:0]     shWrPtr;
    logic [PW-1:0]     shRdPtr;

    // Instruction FIFO and the shadow FIFO of issued PCs
    logic [INST_W-1:0] instMem [DEPTH];
    logic [ADDR_W-1:0] pcMem   [DEPTH];
    logic [ADDR_W-1:0] shMem   [DEPTH];

    logic              respTaken;
    logic              respKeep;
    logic              fire;
    logic              pop;
    logic              fifoPush;
    logic              fifoPop;
    logic [CW:0]       inFlight;

    always_comb begin
        // A response with nothing outstanding is a protocol error and is ignored entirely.
        respTaken = respValid && (outCnt != '0);
        // Responses still owed to a redirected path, or arriving in a jump cycle, are discarded.
        respKeep  = respTaken && (dropCnt == '0) && !jump;

        // Credit: buffered plus outstanding never exceeds DEPTH, so a kept response always fits.
        inFlight  = {1'b0, count} + {1'b0, outCnt};
        reqValid  = rst && !jump && (inFlight < DEPTH_C);
        reqAddr   = fetchPc;
        fire      = reqValid && reqReady;

        instValidF = 1'b0;
        instF      = '0;
        pcF        = '0;
`ifdef FETCH_BYPASS_EN
        if (count != '0) begin
            instValidF = 1'b1;
            instF      = instMem[rdPtr];
            pcF        = pcMem[rdPtr];
        end else if (respKeep) begin
            instValidF = 1'b1;
            instF      = respData;
            pcF        = shMem[shRdPtr];
        end
        pop      = instValidF && !stallF && !jump;
        // A bypassed response that is consumed immediately never touches the FIFO.
        fifoPop  = pop && (count != '0);
        fifoPush = respKeep && !(pop && (count == '0));
`else
        if (count != '0) begin
            instValidF = 1'b1;
            instF      = instMem[rdPtr];
            pcF        = pcMem[rdPtr];
        end
        pop      = instValidF && !stallF && !jump;
        fifoPop  = pop;
        fifoPush = respKeep;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc <= RESET_PC;
            count   <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            shWrPtr <= '0;
            shRdPtr <= '0;
            outCnt  <= '0;
            dropCnt <= '0;
        end else begin
            // Shadow PC FIFO tracks every issued request, independent of redirects,
            // so it stays aligned with the in-order response stream.
            if (fire) begin
                shWrPtr <= shWrPtr + PW'(1);
            end
            if (respTaken) begin
                shRdPtr <= shRdPtr + PW'(1);
            end

            case ({fire, respTaken})
                2'b10:   outCnt <= outCnt + CW'(1);
                2'b01:   outCnt <= outCnt - CW'(1);
                default: ;
            endcase

            if (jump) begin
                fetchPc <= jumpAddr;
                count   <= '0;
                wrPtr   <= '0;
                rdPtr   <= '0;
                // Every request still in flight after this cycle belongs to the old path.
                // Earlier drops are already part of outCnt, so back-to-back jumps do not
                // double count and dropCnt stays bounded by DEPTH.
                dropCnt <= respTaken ? (outCnt - CW'(1)) : outCnt;
            end else begin
                if (fire) begin
                    fetchPc <= fetchPc + ADDR_W'(4);
                end
                if (respTaken && (dropCnt != '0)) begin
                    dropCnt <= dropCnt - CW'(1);
                end
                if (fifoPush) begin
                    wrPtr <= wrPtr + PW'(1);
                end
                if (fifoPop) begin
                    rdPtr <= rdPtr + PW'(1);
                end
                case ({fifoPush, fifoPop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Storage arrays carry no reset; validity is governed by count and the pointers.
    always_ff @(posedge clk) begin
        if (fifoPush) begin
            instMem[wrPtr] <= respData;
            pcMem[wrPtr]   <= shMem[shRdPtr];
        end
        if (fire) begin
            shMem[shWrPtr] <= fetchPc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump;
    logic [63:0] jumpAddr;
    logic        stallF;
    logic        reqValid;
    logic [63:0] reqAddr;
    logic        reqReady;
    logic        respValid;
    logic [31:0] respData;
    logic        instValidF;
    logic [31:0] instF;
    logic [63:0] pcF;

    ifu_fetch_queue dut (
        .clk(clk), .rst(rst), .jump(jump), .jumpAddr(jumpAddr), .stallF(stallF),
        .reqValid(reqValid), .reqAddr(reqAddr), .reqReady(reqReady),
        .respValid(respValid), .respData(respData),
        .instValidF(instValidF), .instF(instF), .pcF(pcF)
    );

    always #5 clk = ~clk;

    // Reference model: requests in flight (in memory order) and instructions IF should see.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
        int          ready;
        bit          stale;
    } req_t;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    req_t        outq[$];
    ent_t        expq[$];
    logic [63:0] modelPc;
    int          cyc;
    int          lastReady;
    bit          inReset;
    int          errors;
    int          checks;

    // Stimulus knobs
    int pJump, pStall, pReady, latMin, latMax;
    bit dataConst;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [63:0] pickAddr();
        logic [63:0] a;
        if ($urandom_range(3) == 0) begin
            a = 64'hFFFF_FFFF_FFFF_FFF8;
        end else begin
            a = {$urandom(), $urandom()};
            a[1:0] = 2'b00;
        end
        return a;
    endfunction

    // One clock cycle: drive at posedge+1, check request port at negedge, update model after.
    task automatic step();
        bit   respNow;
        bit   expReqValid;
        bit   fire;
        req_t r;
        int   lat;
        @(posedge clk);
        #1;
        cyc++;
        jump     = ($urandom_range(99) < pJump);
        jumpAddr = jump ? pickAddr() : 64'h0;
        stallF   = ($urandom_range(99) < pStall);
        reqReady = ($urandom_range(99) < pReady);
        respNow  = (outq.size() > 0) && (outq[0].ready <= cyc);
        respValid = respNow;
        respData  = respNow ? outq[0].data : 32'h0;
        expReqValid = !jump && ((expq.size() + outq.size()) < DEPTH);
        #4;
        chk("reqValid", reqValid, expReqValid);
        if (expReqValid) chk("reqAddr", reqAddr, modelPc);
        #2;
        fire = expReqValid && reqReady;
        if (respNow) begin
            r = outq.pop_front();
            if (!jump && !r.stale) expq.push_back('{pc: r.pc, inst: r.data});
        end
        if (jump) begin
            expq.delete();
            foreach (outq[i]) outq[i].stale = 1'b1;
            modelPc = jumpAddr;
        end else if (fire) begin
            lat = $urandom_range(latMax, latMin);
            r.pc    = modelPc;
            r.data  = dataConst ? 32'h0000_0013 : 32'($urandom());
            r.ready = (cyc + lat > lastReady) ? cyc + lat : lastReady + 1;
            r.stale = 1'b0;
            lastReady = r.ready;
            outq.push_back(r);
            modelPc = modelPc + 64'd4;
        end
    endtask

    task automatic setKnobs(int j, int s, int rd, int lmin, int lmax, bit dc);
        pJump = j; pStall = s; pReady = rd; latMin = lmin; latMax = lmax; dataConst = dc;
    endtask

    task automatic checkResetOutputs(string tag);
        chk({tag, " instValidF"}, instValidF, 1'b0);
        chk({tag, " instF"}, instF, 32'h0);
        chk({tag, " pcF"}, pcF, 64'h0);
        chk({tag, " reqValid"}, reqValid, 1'b0);
    endtask

    // Monitor: compares the IF-side stream against the scoreboard head every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!inReset) begin
                if (expq.size() > 0) begin
                    chk("instValidF", instValidF, 1'b1);
                    chk("pcF", pcF, expq[0].pc);
                    chk("instF", instF, expq[0].inst);
                    if (!stallF && !jump) void'(expq.pop_front());
                end else begin
                    chk("instValidF idle", instValidF, 1'b0);
                end
            end
        end
    end

    initial begin
        int budget;
        errors = 0; checks = 0; cyc = 0; lastReady = 0;
        modelPc = RESET_PC;
        rst = 1'b0; inReset = 1'b1;
        jump = 1'b0; jumpAddr = 64'h0; stallF = 1'b0; reqReady = 1'b0;
        respValid = 1'b0; respData = 32'h0;
        setKnobs(0, 0, 100, 1, 1, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1 rst = 1'b1; inReset = 1'b0;

        // Straight-line fetch with a 1-cycle memory returning 0x13
        setKnobs(0, 0, 100, 1, 1, 1'b1);
        repeat (20) step();

        // IF stalled: issue must stop at DEPTH credits with the head held
        setKnobs(0, 100, 100, 1, 1, 1'b0);
        repeat (10) step();
        setKnobs(0, 0, 100, 1, 1, 1'b0);
        repeat (8) step();

        // Slow memory with redirects while requests are outstanding
        setKnobs(10, 0, 100, 3, 3, 1'b0);
        repeat (300) step();

        // Toggling reqReady
        setKnobs(0, 0, 50, 1, 2, 1'b0);
        repeat (100) step();

        // Everything randomized, including back-to-back jumps
        setKnobs(8, 30, 60, 1, 4, 1'b0);
        repeat (3000) step();
        setKnobs(30, 10, 90, 1, 3, 1'b0);
        repeat (500) step();

        // Fill to three buffered entries, then reset mid-stream
        setKnobs(0, 100, 100, 1, 1, 1'b0);
        budget = 50;
        while (expq.size() < 3 && budget > 0) begin
            step();
            budget--;
        end
        chk("prefill before reset", expq.size() >= 3, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0; inReset = 1'b1;
        jump = 1'b0; reqReady = 1'b0; respValid = 1'b0; respData = 32'h0; stallF = 1'b0;
        #1;
        checkResetOutputs("midreset");
        expq.delete();
        outq.delete();
        modelPc = RESET_PC;
        lastReady = cyc;
        @(posedge clk);
        #1 rst = 1'b1; inReset = 1'b0;

        // Restart from RESET_PC with no stale instructions
        setKnobs(0, 0, 100, 1, 1, 1'b1);
        repeat (20) step();

        // Drain: nothing new accepted, all outstanding returns and is consumed
        setKnobs(0, 0, 0, 1, 1, 1'b0);
        repeat (15) step();
        chk("drained outstanding", outq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
